// File: rtl/gecko_data_memory_pkg.sv
// Shared helpers for the gecko data memory: byte-lane geometry and the
// byte-address to word-index mapping.
package gecko_data_memory_pkg;

    localparam int GECKO_BYTE_W     = 8;
    localparam int GECKO_BYTE_LANES = 4;

    // Drops the in-word byte offset and keeps idx_w bits, so addresses alias modulo the array size.
    function automatic logic [63:0] gecko_mem_word_index(input logic [63:0] addr, input int idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return (addr >> $clog2(GECKO_BYTE_LANES)) & mask;
    endfunction

endpackage

// File: rtl/std_mem_intf.sv
// Generic memory request/response channel; the same bundle carries requests
// toward a memory and read responses back from it.
interface std_mem_intf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic                    read_enable;
    logic [DATA_WIDTH/8-1:0] write_enable;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data;

    modport in  (input valid, read_enable, write_enable, addr, data, output ready);
    modport out (output valid, read_enable, write_enable, addr, data, input ready);
endinterface

// File: rtl/gecko_data_memory_buffer.sv
// Response FIFO for the data memory; the head entry is presented directly
// and only changes on a pop, so stalled output stays stable.
module gecko_data_memory_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int SLOTS      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic                         valid,
    output logic [DATA_WIDTH-1:0]        data,
    output logic [$clog2(SLOTS+1)-1:0]   count
);
    localparam int PTR_W = $clog2(SLOTS);
    localparam int CNT_W = $clog2(SLOTS + 1);

    logic [DATA_WIDTH-1:0] slot_q [SLOTS];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SLOTS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        push_ok  = push && (count_q != CNT_W'(SLOTS));
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) slot_q[wr_ptr_q] <= push_data;
    end

    assign valid = (count_q != '0);
    assign data  = slot_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/gecko_data_memory.sv
// Single-ported word data memory: byte-masked writes, read-first reads with
// one cycle of array latency, responses returned in order through a credited FIFO.
module gecko_data_memory
    import gecko_data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter     INIT_FILE  = "",
    parameter int RESP_SLOTS = 2
) (
    input  logic     clk,
    input  logic     rst,
    std_mem_intf.in  mem_request,
    std_mem_intf.out mem_result
);
    localparam int LANES = DATA_WIDTH / GECKO_BYTE_W;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(RESP_SLOTS + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [IDX_W-1:0]      word_idx;
    logic                  accept, rd_accept;
    logic                  buf_pop, buf_valid;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [CNT_W-1:0]      buf_count;
    logic [CNT_W:0]        credit_used;

    assign req_addr = mem_request.addr;
    assign word_idx = IDX_W'(gecko_mem_word_index(64'(req_addr), IDX_W));

    // Credit counts the read still in the array pipeline, so a stalled consumer
    // can never overflow the FIFO; only registered state feeds ready.
    assign credit_used       = {1'b0, buf_count} + (CNT_W + 1)'(inflight_q);
    assign mem_request.ready = rst && (credit_used < (CNT_W + 1)'(RESP_SLOTS));

    assign accept     = mem_request.valid && mem_request.ready;
    assign rd_accept  = accept && mem_request.read_enable;
    assign inflight_d = rd_accept;

    always_ff @(posedge clk) begin
        if (!rst) inflight_q <= 1'b0;
        else      inflight_q <= inflight_d;
    end

    // Non-blocking read and write of the same word give read-first behaviour.
    always_ff @(posedge clk) begin
        if (rd_accept) rdata_q <= mem_q[word_idx];
        for (int i = 0; i < LANES; i++) begin
            if (accept && mem_request.write_enable[i])
                mem_q[word_idx][GECKO_BYTE_W*i +: GECKO_BYTE_W] <=
                    mem_request.data[GECKO_BYTE_W*i +: GECKO_BYTE_W];
        end
    end

    assign buf_pop = buf_valid && mem_result.ready;

    gecko_data_memory_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .SLOTS      (RESP_SLOTS)
    ) u_resp_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (rdata_q),
        .pop       (buf_pop),
        .valid     (buf_valid),
        .data      (buf_data),
        .count     (buf_count)
    );

    assign mem_result.valid        = buf_valid;
    assign mem_result.data         = buf_data;
    assign mem_result.read_enable  = 1'b0;
    assign mem_result.write_enable = '0;
    assign mem_result.addr         = '0;

endmodule

// File: tb/tb_gecko_data_memory.sv
// Scoreboard bench for gecko_data_memory: a byte-lane memory model predicts
// every read response, which is compared when the DUT hands it over.
module tb_gecko_data_memory;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int SLOTS = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    std_mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) req_if ();
    std_mem_intf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) res_if ();

    gecko_data_memory #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .INIT_FILE  (""),
        .RESP_SLOTS (SLOTS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_request (req_if),
        .mem_result  (res_if)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];
    int          mon_idx;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Monitor: sample mid-cycle, predicting accepts and checking pops at the next edge.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (res_if.valid && res_if.ready) begin
                check_eq("resp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_eq("resp_data", res_if.data, exp_q.pop_front());
            end
            if (req_if.valid && req_if.ready) begin
                mon_idx = int'((req_if.addr >> 2) % DEPTH);
                if (req_if.read_enable) exp_q.push_back(model[mon_idx]);
                for (int i = 0; i < 4; i++)
                    if (req_if.write_enable[i]) model[mon_idx][8*i +: 8] = req_if.data[8*i +: 8];
            end
        end
    end

    task automatic do_req(input logic re, input logic [3:0] we, input logic [31:0] addr,
                          input logic [31:0] data);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        req_if.read_enable  = re;
        req_if.write_enable = we;
        req_if.addr         = addr;
        req_if.data         = data;
        req_if.valid        = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = req_if.ready;
            @(posedge clk); #1;
            n++;
        end
        req_if.valid        = 1'b0;
        req_if.read_enable  = 1'b0;
        req_if.write_enable = '0;
        check_eq("req_accept", 32'(acc), 32'd1);
    endtask

    task automatic stream(input logic re, input logic [3:0] we, input logic [31:0] base,
                          input int n, input int budget, output int done, output int cycles);
        logic a;
        done   = 0;
        cycles = 0;
        req_if.read_enable  = re;
        req_if.write_enable = we;
        req_if.addr         = base;
        req_if.data         = {16'hC0DE, 16'd0};
        req_if.valid        = 1'b1;
        while (done < n && cycles < budget) begin
            @(negedge clk);
            a = req_if.ready;
            @(posedge clk); #1;
            cycles++;
            if (a) begin
                done++;
                req_if.addr = base + 32'(4 * done);
                req_if.data = {16'hC0DE, 16'(done)};
            end
        end
        req_if.valid        = 1'b0;
        req_if.read_enable  = 1'b0;
        req_if.write_enable = '0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || res_if.valid) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int          done, cyc, n;
        logic        a, stale;
        logic [31:0] r, held;

        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        req_if.valid        = 1'b0;
        req_if.read_enable  = 1'b0;
        req_if.write_enable = '0;
        req_if.addr         = '0;
        req_if.data         = '0;
        res_if.ready        = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(req_if.ready), 32'd0);
        check_eq("rst_valid", 32'(res_if.valid), 32'd0);
        check_eq("res_side", 32'({res_if.read_enable, res_if.write_enable}) | res_if.addr, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("ready_after_rst", 32'(req_if.ready), 32'd1);
        res_if.ready = 1'b1;

        // Full write then read: response appears two cycles after accept.
        do_req(1'b0, 4'hF, 32'h40, 32'hDEADBEEF);
        do_req(1'b1, 4'h0, 32'h40, 32'h0);
        @(negedge clk);
        check_eq("lat_cycle1", 32'(res_if.valid), 32'd0);
        @(negedge clk);
        check_eq("lat_cycle2", 32'(res_if.valid), 32'd1);
        @(posedge clk); #1;
        drain("t1_drain");

        // Byte-lane merges, ignored low bits and aliasing above the array.
        do_req(1'b0, 4'hF, 32'h8, 32'h11223344);
        do_req(1'b0, 4'h1, 32'h8, 32'h000000AA);
        do_req(1'b0, 4'h2, 32'h8, 32'h0000BB00);
        do_req(1'b1, 4'h0, 32'h8, 32'h0);
        do_req(1'b1, 4'h0, 32'hB, 32'h0);
        do_req(1'b1, 4'h0, 32'h1008, 32'h0);
        drain("t2_drain");

        // Read-first on a combined request.
        do_req(1'b0, 4'hF, 32'h10, 32'h5);
        do_req(1'b1, 4'hF, 32'h10, 32'h9);
        do_req(1'b1, 4'h0, 32'h10, 32'h0);
        drain("t3_drain");

        // Backpressure: only the credit's worth of reads gets in.
        stream(1'b0, 4'hF, 32'h100, 4, 40, done, cyc);
        drain("bp_init_drain");
        res_if.ready = 1'b0;
        stream(1'b1, 4'h0, 32'h100, 4, 10, done, cyc);
        check_eq("bp_accepts", 32'(done), 32'd2);
        check_eq("bp_ready_low", 32'(req_if.ready), 32'd0);
        check_eq("bp_valid", 32'(res_if.valid), 32'd1);
        held = res_if.data;
        repeat (3) @(posedge clk);
        #1;
        check_eq("bp_stable", res_if.data, held);
        res_if.ready = 1'b1;
        stream(1'b1, 4'h0, 32'h108, 2, 50, done, cyc);
        check_eq("bp_rest", 32'(done), 32'd2);
        drain("bp_drain");

        // Writes flow one per cycle with credit available.
        stream(1'b0, 4'hF, 32'h180, 8, 40, done, cyc);
        check_eq("wr_rate", 32'(cyc), 32'd8);
        stream(1'b1, 4'h0, 32'h180, 8, 60, done, cyc);
        check_eq("rd_stream", 32'(done), 32'd8);
        drain("stream_drain");

        // Random mixed traffic on 16 words with random aliasing bits.
        stream(1'b0, 4'hF, 32'h200, 16, 60, done, cyc);
        drain("rand_init_drain");
        n   = 0;
        cyc = 0;
        while (n < 1000 && cyc < 20000) begin
            if (!req_if.valid && $urandom_range(0, 1) == 1) begin
                r = $urandom();
                req_if.read_enable  = 1'($urandom());
                req_if.write_enable = 4'($urandom());
                req_if.addr         = {r[31:12], 6'b001000, r[3:0], r[5:4]};
                req_if.data         = $urandom();
                req_if.valid        = 1'b1;
            end
            res_if.ready = 1'($urandom());
            @(negedge clk);
            a = req_if.valid && req_if.ready;
            @(posedge clk); #1;
            cyc++;
            if (a) begin
                n++;
                req_if.valid = 1'b0;
            end
        end
        req_if.valid = 1'b0;
        check_eq("rand_ops", 32'(n), 32'd1000);
        res_if.ready = 1'b1;
        drain("rand_drain");

        // Reset with one response buffered and one read in flight.
        do_req(1'b0, 4'hF, 32'h300, 32'hCAFEF00D);
        res_if.ready = 1'b0;
        stream(1'b1, 4'h0, 32'h300, 2, 10, done, cyc);
        check_eq("credit_full", 32'(req_if.ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_valid", 32'(res_if.valid), 32'd0);
        rst = 1'b1;
        res_if.ready = 1'b1;
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (res_if.valid) stale = 1'b1;
        end
        @(posedge clk); #1;
        check_eq("rst_no_stale", 32'(stale), 32'd0);
        do_req(1'b1, 4'h0, 32'h300, 32'h0);
        do_req(1'b1, 4'h0, 32'h40, 32'h0);
        drain("post_rst_drain");

        check_eq("sb_final", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
